// File: rtl/glyph_ctrl_pkg.sv
// Shared constants and FSM state type for the signed-value glyph sequencer.
package glyph_ctrl_pkg;

   localparam int DEF_VAL_W     = 16;
   localparam int DEF_DIGITS    = 5;
   localparam int DEF_GLYPH_W   = 18;
   localparam int DEF_GLYPH_GAP = 2;
   localparam int BCD_W         = 4 * DEF_DIGITS;
   localparam int GLYPH_H       = 25;
   localparam int CELL_PITCH    = DEF_GLYPH_W + DEF_GLYPH_GAP;
   localparam int COORD_W       = 13;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ABS,
      ST_SHIFT,
      ST_PEND,
      ST_COMMIT
   } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by one.
// Purely combinational; no handshake.
module bcd_dabble_step #(
   parameter int BCD_BITS = 20,
   parameter int MAG_W    = 16
) (
   input  logic [BCD_BITS-1:0] bcd_i,
   input  logic [MAG_W-1:0]    mag_i,
   output logic [BCD_BITS-1:0] bcd_o,
   output logic [MAG_W-1:0]    mag_o
);

   logic [BCD_BITS-1:0] adj;

   always_comb begin
      adj = bcd_i;
      for (int k = 0; k < BCD_BITS / 4; k++) begin
         if (bcd_i[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = bcd_i[4*k +: 4] + 4'd3;
         end
      end
   end

   assign {bcd_o, mag_o} = {adj, mag_i} << 1;

endmodule

// File: rtl/signed_value_glyph_ctrl.sv
// Signed value -> per-glyph controls; iterative BCD conversion, display committed only on a frame-start pulse.
// Load accepted only when o_ready; leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module signed_value_glyph_ctrl
   import glyph_ctrl_pkg::*;
#(
   parameter int VAL_W     = DEF_VAL_W,
   parameter int DIGITS    = DEF_DIGITS,
   parameter int GLYPH_W   = DEF_GLYPH_W,
   parameter int GLYPH_GAP = DEF_GLYPH_GAP,
   parameter int ORIGIN_X  = 0,
   parameter int ORIGIN_Y  = 0
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [VAL_W-1:0]              i_value,
   input  logic                          i_load,
   input  logic                          i_frame_start,
   output logic                          o_ready,
   output logic                          o_busy,
   output logic                          o_minus_en,
   output logic [DIGITS-1:0]             o_digit_en,
   output logic [4*DIGITS-1:0]           o_digit_val,
   output logic [COORD_W*(DIGITS+1)-1:0] o_glyph_x,
   output logic [COORD_W-1:0]            o_glyph_y
);

   localparam int BCD_BITS = 4 * DIGITS;
   localparam int ITER_W   = $clog2(VAL_W);
   localparam int PITCH    = GLYPH_W + GLYPH_GAP;

   state_t              state_q, state_d;
   logic [VAL_W-1:0]    val_q, val_d;
   logic                sign_q, sign_d;
   logic [VAL_W-1:0]    mag_q, mag_d;
   logic [BCD_BITS-1:0] bcd_q, bcd_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic                minus_en_q, minus_en_d;
   logic [DIGITS-1:0]   digit_en_q, digit_en_d;
   logic [BCD_BITS-1:0] digit_val_q, digit_val_d;

   logic [BCD_BITS-1:0] step_bcd;
   logic [VAL_W-1:0]    step_mag;
   logic [DIGITS-1:0]   commit_en;

   bcd_dabble_step #(
      .BCD_BITS (BCD_BITS),
      .MAG_W    (VAL_W)
   ) u_step (
      .bcd_i (bcd_q),
      .mag_i (mag_q),
      .bcd_o (step_bcd),
      .mag_o (step_mag)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Scan from the MS digit down; a digit is shown once any digit at or above it is non-zero.
   always_comb begin
      logic seen;
      seen      = 1'b0;
      commit_en = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         seen         = seen | (bcd_q[4*k +: 4] != 4'd0) | (k == 0);
         commit_en[k] = seen;
      end
   end
`else
   assign commit_en = '1;
`endif

   always_comb begin
      state_d     = state_q;
      val_d       = val_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      bcd_d       = bcd_q;
      iter_d      = iter_q;
      minus_en_d  = minus_en_q;
      digit_en_d  = digit_en_q;
      digit_val_d = digit_val_q;
      case (state_q)
         ST_IDLE: begin
            if (i_load) begin
               val_d   = i_value;
               state_d = ST_ABS;
            end
         end
         ST_ABS: begin
            // Unsigned negation maps the most negative value onto 2^(VAL_W-1) without overflow.
            sign_d  = val_q[VAL_W-1];
            mag_d   = val_q[VAL_W-1] ? (-val_q) : val_q;
            bcd_d   = '0;
            iter_d  = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            bcd_d  = step_bcd;
            mag_d  = step_mag;
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_W'(VAL_W - 1)) begin
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (i_frame_start) begin
               minus_en_d  = sign_q && (bcd_q != '0);
               digit_en_d  = commit_en;
               digit_val_d = bcd_q;
               state_d     = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         val_q       <= '0;
         sign_q      <= 1'b0;
         mag_q       <= '0;
         bcd_q       <= '0;
         iter_q      <= '0;
         minus_en_q  <= 1'b0;
         digit_en_q  <= '0;
         digit_val_q <= '0;
      end else begin
         state_q     <= state_d;
         val_q       <= val_d;
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         bcd_q       <= bcd_d;
         iter_q      <= iter_d;
         minus_en_q  <= minus_en_d;
         digit_en_q  <= digit_en_d;
         digit_val_q <= digit_val_d;
      end
   end

   assign o_ready     = (state_q == ST_IDLE);
   assign o_busy      = !o_ready;
   assign o_minus_en  = minus_en_q;
   assign o_digit_en  = digit_en_q;
   assign o_digit_val = digit_val_q;
   assign o_glyph_y   = COORD_W'(ORIGIN_Y);

   // Cell 0 is the minus sign, cells 1..DIGITS run from the MS digit to units.
   for (genvar c = 0; c <= DIGITS; c++) begin : g_cell_x
      assign o_glyph_x[COORD_W*c +: COORD_W] = COORD_W'(ORIGIN_X + c * PITCH);
   end

endmodule
